cdb_arbiter: RTL and testbench

- Shares one registered common-data-bus (CDB) write-back port into the ROB between several result producers: ALU RS, LSB load path and branch unit.
- Each producer hands off one result through a valid/ready handshake into a one-entry holding slot.
- A round-robin scheduler drains one slot per cycle onto the CDB, which feeds the ROB's result input and RS/LSB wakeup.
- A ROB clear (mispredict flush) discards all buffered results.

---
 rtl/cdb_arbiter.sv | 107 ++++++++++
 tb/tb_cdb_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one holding slot per result producer, round-robin drain
// onto a single registered write-back port shared by the ROB and RS/LSB wakeup.
module cdb_arbiter #(
  parameter int unsigned NUM_REQ  = 3,
  parameter int unsigned ROB_ID_W = 5,
  parameter int unsigned DATA_W   = 32
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic                          rdy_in,
  input  logic                          flush_in,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ROB_ID_W-1:0]   req_rob_id,
  input  logic [NUM_REQ*DATA_W-1:0]     req_value,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          cdb_valid,
  output logic [ROB_ID_W-1:0]           cdb_rob_id,
  output logic [DATA_W-1:0]             cdb_value,
  output logic [$clog2(NUM_REQ)-1:0]    cdb_src
);

  localparam int unsigned SRC_W = $clog2(NUM_REQ);
  // One extra bit so rr_ptr + offset cannot overflow before the wrap subtract.
  localparam int unsigned IDX_W = SRC_W + 1;

  logic [NUM_REQ-1:0]  slot_valid;
  logic [ROB_ID_W-1:0] slot_id  [NUM_REQ];
  logic [DATA_W-1:0]   slot_val [NUM_REQ];
  logic [SRC_W-1:0]    rr_ptr;

  logic [NUM_REQ-1:0]  grant;
  logic                any_grant;
  logic [SRC_W-1:0]    grant_idx;
  logic [SRC_W-1:0]    rr_next;
  logic [IDX_W-1:0]    scan_idx;
  logic [SRC_W-1:0]    scan_sel;

  // Round-robin search starting at rr_ptr; first valid slot wins.
  always_comb begin
    grant     = '0;
    any_grant = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    scan_sel  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = IDX_W'(rr_ptr) + IDX_W'(k);
      if (scan_idx >= IDX_W'(NUM_REQ)) begin
        scan_idx = scan_idx - IDX_W'(NUM_REQ);
      end
      scan_sel = SRC_W'(scan_idx);
      if (!any_grant && slot_valid[scan_sel]) begin
        grant[scan_sel] = 1'b1;
        any_grant       = 1'b1;
        grant_idx       = scan_sel;
      end
    end
  end

  always_comb begin
    rr_next = grant_idx + SRC_W'(1);
    if (grant_idx == SRC_W'(NUM_REQ - 1)) begin
      rr_next = '0;
    end
  end

  // A slot being drained this cycle may be refilled in the same cycle.
  assign req_ready = {NUM_REQ{rdy_in & ~flush_in}} & (~slot_valid | grant);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      slot_valid <= '0;
      rr_ptr     <= '0;
      cdb_valid  <= 1'b0;
      cdb_rob_id <= '0;
      cdb_value  <= '0;
      cdb_src    <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        slot_id[i]  <= '0;
        slot_val[i] <= '0;
      end
    end else if (rdy_in) begin
      if (flush_in) begin
        slot_valid <= '0;
        cdb_valid  <= 1'b0;
        rr_ptr     <= '0;
      end else begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          if (req_valid[i] && req_ready[i]) begin
            slot_valid[i] <= 1'b1;
            slot_id[i]    <= req_rob_id[i*ROB_ID_W +: ROB_ID_W];
            slot_val[i]   <= req_value[i*DATA_W +: DATA_W];
          end else if (grant[i]) begin
            slot_valid[i] <= 1'b0;
          end
        end
        cdb_valid <= any_grant;
        if (any_grant) begin
          cdb_rob_id <= slot_id[grant_idx];
          cdb_value  <= slot_val[grant_idx];
          cdb_src    <= grant_idx;
          rr_ptr     <= rr_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, latency, round-robin, streaming, flush,
// stall and asynchronous reset, each with hand-computed expectations.
module tb_cdb_arbiter;

  localparam int unsigned NUM_REQ  = 3;
  localparam int unsigned ROB_ID_W = 5;
  localparam int unsigned DATA_W   = 32;

  logic                        clk_in;
  logic                        rst_n_in;
  logic                        rdy_in;
  logic                        flush_in;
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ*ROB_ID_W-1:0] req_rob_id;
  logic [NUM_REQ*DATA_W-1:0]   req_value;
  logic [NUM_REQ-1:0]          req_ready;
  logic                        cdb_valid;
  logic [ROB_ID_W-1:0]         cdb_rob_id;
  logic [DATA_W-1:0]           cdb_value;
  logic [1:0]                  cdb_src;

  int tests;
  int fails;

  cdb_arbiter #(.NUM_REQ(NUM_REQ), .ROB_ID_W(ROB_ID_W), .DATA_W(DATA_W)) dut (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .rdy_in     (rdy_in),
    .flush_in   (flush_in),
    .req_valid  (req_valid),
    .req_rob_id (req_rob_id),
    .req_value  (req_value),
    .req_ready  (req_ready),
    .cdb_valid  (cdb_valid),
    .cdb_rob_id (cdb_rob_id),
    .cdb_value  (cdb_value),
    .cdb_src    (cdb_src)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_req(input int i, input logic [ROB_ID_W-1:0] id, input logic [DATA_W-1:0] val);
    req_rob_id[i*ROB_ID_W +: ROB_ID_W] = id;
    req_value[i*DATA_W +: DATA_W]      = val;
  endtask

  task automatic chk_cdb(input string tag, input logic [1:0] src,
                         input logic [ROB_ID_W-1:0] id, input logic [DATA_W-1:0] val);
    chk({tag, "_valid"}, 64'(cdb_valid), 64'd1);
    chk({tag, "_src"},   64'(cdb_src),   64'(src));
    chk({tag, "_id"},    64'(cdb_rob_id), 64'(id));
    chk({tag, "_value"}, 64'(cdb_value), 64'(val));
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n_in   = 1'b0;
    rdy_in     = 1'b1;
    flush_in   = 1'b0;
    req_valid  = '0;
    req_rob_id = '0;
    req_value  = '0;

    // Reset state
    #12;
    chk("rst_valid", 64'(cdb_valid), 64'd0);
    chk("rst_id",    64'(cdb_rob_id), 64'd0);
    chk("rst_value", 64'(cdb_value), 64'd0);
    chk("rst_src",   64'(cdb_src),   64'd0);
    step();
    rst_n_in = 1'b1;
    step();

    // Single result: two-edge latency
    set_req(0, 5'd5, 32'h1234);
    req_valid = 3'b001;
    #1;
    chk("t1_ready", 64'(req_ready), 64'b111);
    step();
    req_valid = '0;
    chk("t1_lat_valid", 64'(cdb_valid), 64'd0);
    step();
    chk_cdb("t1_cdb", 2'd0, 5'd5, 32'h1234);
    step();
    chk("t1_after_valid", 64'(cdb_valid), 64'd0);

    // Restart rr_ptr, then three-way contention
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    set_req(0, 5'd1, 32'h101);
    set_req(1, 5'd2, 32'h102);
    set_req(2, 5'd3, 32'h103);
    req_valid = 3'b111;
    for (int j = 1; j <= 7; j++) begin
      step();
      chk($sformatf("rr_ready_%0d", j), 64'(req_ready), 64'(3'b001 << ((j - 1) % 3)));
      if (j >= 2) begin
        chk_cdb($sformatf("rr_cdb_%0d", j), 2'((j - 2) % 3),
                5'((j - 2) % 3 + 1), 32'h101 + 32'((j - 2) % 3));
      end
    end
    req_valid = '0;
    step();
    step();
    step();
    step();
    chk("rr_drained_valid", 64'(cdb_valid), 64'd0);

    // Back-to-back stream from requester 1
    set_req(1, 5'd7, 32'h70);
    req_valid = 3'b010;
    #1;
    chk("b2b_ready_7", 64'(req_ready[1]), 64'd1);
    step();
    set_req(1, 5'd8, 32'h80);
    #1;
    chk("b2b_ready_8", 64'(req_ready[1]), 64'd1);
    step();
    chk_cdb("b2b_cdb_7", 2'd1, 5'd7, 32'h70);
    set_req(1, 5'd9, 32'h90);
    #1;
    chk("b2b_ready_9", 64'(req_ready[1]), 64'd1);
    step();
    chk_cdb("b2b_cdb_8", 2'd1, 5'd8, 32'h80);
    req_valid = '0;
    step();
    chk_cdb("b2b_cdb_9", 2'd1, 5'd9, 32'h90);
    step();
    chk("b2b_end_valid", 64'(cdb_valid), 64'd0);

    // Flush with all slots full
    set_req(0, 5'd10, 32'hA0);
    set_req(1, 5'd11, 32'hB0);
    set_req(2, 5'd12, 32'hC0);
    req_valid = 3'b111;
    step();
    req_valid = '0;
    flush_in  = 1'b1;
    #1;
    chk("fl_ready", 64'(req_ready), 64'b000);
    step();
    flush_in = 1'b0;
    chk("fl_valid_0", 64'(cdb_valid), 64'd0);
    for (int j = 1; j <= 3; j++) begin
      step();
      chk($sformatf("fl_valid_%0d", j), 64'(cdb_valid), 64'd0);
    end
    set_req(0, 5'd20, 32'h200);
    set_req(1, 5'd21, 32'h210);
    set_req(2, 5'd22, 32'h220);
    req_valid = 3'b111;
    step();
    req_valid = '0;
    step();
    chk_cdb("fl_post_0", 2'd0, 5'd20, 32'h200);
    step();
    chk_cdb("fl_post_1", 2'd1, 5'd21, 32'h210);
    step();
    chk_cdb("fl_post_2", 2'd2, 5'd22, 32'h220);
    step();
    chk("fl_post_end", 64'(cdb_valid), 64'd0);

    // Stall: slots 0 and 2 full, CDB showing id 4
    set_req(0, 5'd4, 32'h44);
    set_req(2, 5'd6, 32'h66);
    req_valid = 3'b101;
    step();
    set_req(0, 5'd5, 32'h55);
    step();
    chk_cdb("st_pre", 2'd0, 5'd4, 32'h44);
    req_valid = '0;
    rdy_in    = 1'b0;
    #1;
    chk("st_ready_0", 64'(req_ready), 64'b000);
    for (int j = 1; j <= 3; j++) begin
      step();
      chk_cdb($sformatf("st_hold_%0d", j), 2'd0, 5'd4, 32'h44);
      chk($sformatf("st_ready_%0d", j), 64'(req_ready), 64'b000);
    end
    rdy_in = 1'b1;
    step();
    chk_cdb("st_res_2", 2'd2, 5'd6, 32'h66);
    step();
    chk_cdb("st_res_0", 2'd0, 5'd5, 32'h55);
    step();
    chk("st_end_valid", 64'(cdb_valid), 64'd0);

    // Asynchronous reset between edges
    set_req(0, 5'd9, 32'h99);
    req_valid = 3'b001;
    step();
    req_valid = '0;
    step();
    chk_cdb("ar_pre", 2'd0, 5'd9, 32'h99);
    #2;
    rst_n_in = 1'b0;
    #1;
    chk("ar_valid", 64'(cdb_valid), 64'd0);
    chk("ar_id",    64'(cdb_rob_id), 64'd0);
    chk("ar_value", 64'(cdb_value), 64'd0);
    chk("ar_src",   64'(cdb_src),   64'd0);
    #2;
    rst_n_in = 1'b1;
    step();
    chk("ar_post_valid", 64'(cdb_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
